// File: rtl/fpu_wb_buffer.sv
// fpu_wb_buffer: first-word-fall-through result FIFO between the FPU and the register-file writeback port,
// with a sticky accrued-exception register for the CSR unit.
module fpu_wb_buffer #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 5,
  parameter int DEPTH     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       in_result_i,
  input  logic [4:0]             in_status_i,
  input  logic [TAG_WIDTH-1:0]   in_tag_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [WIDTH-1:0]       wb_result_o,
  output logic [TAG_WIDTH-1:0]   wb_tag_o,
  input  logic                   flush_i,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_clr_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0]     r_res [DEPTH];
  logic [4:0]           r_sts [DEPTH];
  logic [TAG_WIDTH-1:0] r_tag [DEPTH];
  logic [AW-1:0]        r_wr, r_rd;
  logic [AW:0]          r_count;
  logic [4:0]           r_fflags;
  logic                 w_push, w_pop;
  // Ready depends only on occupancy so wb_ready_i never reaches in_ready_o combinationally
  assign in_ready_o  = r_count != FULL;
  assign wb_valid_o  = r_count != '0;
  assign busy_o      = wb_valid_o;
  assign count_o     = r_count;
  assign fflags_o    = r_fflags;
  assign wb_result_o = wb_valid_o ? r_res[r_rd] : '0;
  assign wb_tag_o    = wb_valid_o ? r_tag[r_rd] : '0;
  assign w_push      = in_valid_i & in_ready_o & ~flush_i;
  assign w_pop       = wb_valid_o & wb_ready_i & ~flush_i;
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_res[r_wr] <= in_result_i;
      r_sts[r_wr] <= in_status_i;
      r_tag[r_wr] <= in_tag_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_fflags <= '0;
    end else begin
      r_fflags <= (fflags_clr_i ? 5'b0 : r_fflags) | (w_pop ? r_sts[r_rd] : 5'b0);
      if (flush_i) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
      end else begin
        r_wr    <= r_wr + AW'(w_push);
        r_rd    <= r_rd + AW'(w_pop);
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && r_count == FULL));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(w_pop && r_count == '0));
  a_count_bound:  assert property (@(posedge clk_i) disable iff (rst_i) r_count <= FULL);
  a_wb_stable:    assert property (@(posedge clk_i) disable iff (rst_i)
                    (wb_valid_o && !wb_ready_i && !flush_i) |=>
                    (wb_valid_o && $stable(wb_result_o) && $stable(wb_tag_o)));
endmodule

// File: doc/fpu_wb_buffer.md
Name: fpu_wb_buffer

Overview:
- Result/writeback buffer directly downstream of the FPU top-level.
- Accepts the FPU's arbitrated output stream (result, status, tag) over a valid/ready handshake and holds results in a small first-word-fall-through FIFO.
- Presents results to the register-file writeback port and keeps a sticky accrued-exception register (fflags) for the CSR unit.
- Decouples FPU back-pressure from writeback-port arbitration.

Parameters:
- WIDTH, 64, result width in bits; equals the FPU datapath width.
- TAG_WIDTH, 5, width of the tag carried with each result (destination register index).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- in_valid_i  input  1  FPU result valid
- in_ready_o  output  1  buffer can accept a result
- in_result_i  input  WIDTH  FPU result
- in_status_i  input  5  FPU status flags {NV,DZ,OF,UF,NX}, NV at bit 4
- in_tag_i  input  TAG_WIDTH  FPU result tag
- wb_valid_o  output  1  head entry valid for writeback
- wb_ready_i  input  1  writeback port accepts head entry
- wb_result_o  output  WIDTH  head result
- wb_tag_o  output  TAG_WIDTH  head tag
- flush_i  input  1  discard all buffered entries
- fflags_o  output  5  sticky OR of status of all written-back entries
- fflags_clr_i  input  1  clear fflags (CSR write)
- count_o  output  $clog2(DEPTH)+1  current occupancy
- busy_o  output  1  occupancy non-zero

Behaviour:
- Reset (rst_i high at a clock edge): occupancy 0 and read/write pointers 0. After the edge: in_ready_o=1, wb_valid_o=0, count_o=0, busy_o=0, fflags_o=0. wb_result_o and wb_tag_o are 0 while empty.
- Reset mid-operation discards all entries and fflags in the same edge and overrides every other input.
- Push: in_valid_i & in_ready_o at an edge writes {result, status, tag} at the write pointer; the pointer increments modulo DEPTH.
- Pop: wb_valid_o & wb_ready_i at an edge advances the read pointer modulo DEPTH.
- in_ready_o = (count_o != DEPTH). It is a registered/state-only function with no combinational path from wb_ready_i. A full buffer never accepts, even if a pop happens in the same cycle.
- wb_valid_o = (count_o != 0). The head is first-word-fall-through: an entry pushed at edge N is visible on wb_* after edge N, giving 1-cycle latency when empty.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointer wrap: pointers are $clog2(DEPTH) bits; occupancy is tracked by an explicit counter, so full and empty are unambiguous.
- Ordering is strict FIFO; no reordering or tag inspection.
- fflags update at an edge: next = (fflags_clr_i ? 0 : fflags_o) | (pop ? head_status : 0).
  - Clear and pop in the same cycle: fflags_o equals the popped entry's status.
  - Flags accrue only on pop, never on push.
- flush_i at an edge: occupancy and both pointers go to 0.
  - Any concurrent push is dropped. in_ready_o may be 1 that cycle, and the FPU treats the transfer as accepted and discarded.
  - A concurrent pop does not occur: no writeback and no fflags accrual for that cycle.
  - fflags_o is retained, unless fflags_clr_i is also high.
- busy_o = wb_valid_o.
- Storage is a register array with no reset on the data fields; only control state is reset.
- Assertions (verification):
  - No push when full.
  - No pop when empty.
  - wb_* stable while wb_valid_o & !wb_ready_i.
  - count_o ≤ DEPTH.

Test Plan:
- Single pass-through: push result=0x3FF0000000000000, status=5'b00001, tag=3 into the empty buffer with wb_ready_i=1. Required: wb_valid_o=1 with those values one cycle later, popped that cycle, then fflags_o=5'b00001 and count_o=0.
- Fill and back-pressure: DEPTH=4, wb_ready_i=0, push tags 1..5 on consecutive cycles. Required: tags 1..4 accepted, in_ready_o=0 after the 4th push, tag 5 held off. Then wb_ready_i=1 pops tags 1,2,3,4 in order.
- Streaming wrap-around: 20 back-to-back results with tags 0..19 and wb_ready_i=1 continuously. Required: outputs appear in order tags 0..19 with no bubbles after the first, count_o stays at or below 1, and the pointers wrap 5 times with no corruption.
- fflags accrual and clear: pop entries with statuses 5'b10000 then 5'b00100. Required: fflags_o=5'b10100. Then fflags_clr_i=1 together with a pop of status 5'b00001. Required: fflags_o=5'b00001.
- Flush with concurrent push: 3 entries buffered, fflags_o=5'b00010, assert flush_i with in_valid_i=1. Required: next cycle count_o=0, wb_valid_o=0, fflags_o=5'b00010, and the pushed entry never appears.
- Reset mid-stream: 2 entries buffered, fflags nonzero, pulse rst_i for one cycle while in_valid_i=1. Required: count_o=0, wb_valid_o=0, fflags_o=0, in_ready_o=1, and the next push emerges as the sole output.
